// File: rtl/ifetch_queue_if.sv
// Fetch-side bus of ifetch_queue: instruction memory port, redirect request
// and the valid/ready delivery channel towards decode.
interface ifetch_queue_if #(
    parameter int AW     = 13,
    parameter int QDEPTH = 4
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_instr;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic          out_fault;
    logic [CW-1:0] q_count;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr,
        output out_fault,
        output q_count
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr,
        input  out_fault,
        input  q_count
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch sequencer: owns the fetch PC, reads a combinational
// instruction memory and buffers {pc, instr, fault} entries for decode.
module ifetch_queue #(
    parameter int          IMEM_DEPTH = 8192,
    parameter int          QDEPTH     = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic            clk,
    input logic            rst,
    ifetch_queue_if.master bus
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {FETCH, HALT} state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [31:0]   r_fetchPc;
    logic [31:0]   r_pcMem    [QDEPTH];
    logic [31:0]   r_instrMem [QDEPTH];
    logic          r_faultMem [QDEPTH];
    logic [PW-1:0] r_rdPtr;
    logic [PW-1:0] r_wrPtr;
    logic [CW-1:0] r_count;

    logic [31:0]   w_ea;
    logic          w_fault;
    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_countAfterPop;

    // Reset forces the reset PC onto the memory address and masks any redirect.
    always_comb begin
        w_ea = r_fetchPc;
        if (rst) begin
            w_ea = RESET_PC;
        end else if (bus.redirect_valid) begin
            w_ea = bus.redirect_pc;
        end
    end

    assign w_fault         = (w_ea >= 32'(IMEM_DEPTH)) || (w_ea[1:0] != 2'b00);
    assign w_pop           = (r_count != '0) && bus.out_ready;
    assign w_countAfterPop = bus.redirect_valid ? '0 : (r_count - CW'(w_pop));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (bus.redirect_valid) begin
            w_nextState = w_fault ? HALT : FETCH;
        end else if (w_push && w_fault) begin
            w_nextState = HALT;
        end
    end

    always_comb begin
        w_push = 1'b0;
        if ((r_state == FETCH || bus.redirect_valid) && (w_countAfterPop < CW'(QDEPTH))) begin
            w_push = 1'b1;
        end
    end

    // A redirect restarts the queue at the write pointer so the target lands at the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdPtr   <= '0;
            r_wrPtr   <= '0;
            r_count   <= '0;
            r_fetchPc <= RESET_PC;
        end else begin
            if (bus.redirect_valid) begin
                r_rdPtr <= r_wrPtr;
            end else if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
                if (!w_fault) begin
                    r_fetchPc <= w_ea + 32'd4;
                end
            end
            r_count <= w_countAfterPop + CW'(w_push);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_pcMem[r_wrPtr]    <= w_ea;
            r_instrMem[r_wrPtr] <= w_fault ? NOP_INSTR : bus.imem_instr;
            r_faultMem[r_wrPtr] <= w_fault;
        end
    end

    assign bus.imem_addr = w_ea[AW-1:0];
    assign bus.out_valid = (r_count != '0);
    assign bus.q_count   = r_count;
    assign bus.out_pc    = bus.out_valid ? r_pcMem[r_rdPtr]    : 32'd0;
    assign bus.out_instr = bus.out_valid ? r_instrMem[r_rdPtr] : 32'd0;
    assign bus.out_fault = bus.out_valid ? r_faultMem[r_rdPtr] : 1'b0;
endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue: a queue-based model of the fetch rules
// predicts every output each cycle, alongside the directed plan scenarios.
module tb_ifetch_queue;
    localparam int          IMEM_DEPTH = 8192;
    localparam int          QDEPTH     = 4;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          AW         = $clog2(IMEM_DEPTH);
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        bit          fault;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared = 0;
    int   mismatched = 0;

    entry_t      mQ[$];
    bit          mHalted;
    logic [31:0] mPc;

    ifetch_queue_if #(.AW(AW), .QDEPTH(QDEPTH)) bus ();

    ifetch_queue #(
        .IMEM_DEPTH(IMEM_DEPTH),
        .QDEPTH    (QDEPTH),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Memory content: each word holds its own word index.
    always_comb bus.imem_instr = 32'(bus.imem_addr) >> 2;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {19'd0, a[AW-1:0]} >> 2;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
        logic [31:0] ea;
        entry_t      e;
        bit          flt;
        @(negedge clk);
        rst                = r;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.out_ready      = rdy;
        #1;
        ea = r ? RESET_PC : (rv ? rpc : mPc);
        checkOutput("imem_addr", 32'(bus.imem_addr), 32'(ea[AW-1:0]));
        checkOutput("out_valid", 32'(bus.out_valid), 32'(mQ.size() > 0));
        checkOutput("q_count", 32'(bus.q_count), 32'(mQ.size()));
        checkOutput("out_pc", bus.out_pc, (mQ.size() > 0) ? mQ[0].pc : 32'd0);
        checkOutput("out_instr", bus.out_instr, (mQ.size() > 0) ? mQ[0].instr : 32'd0);
        checkOutput("out_fault", 32'(bus.out_fault), (mQ.size() > 0) ? 32'(mQ[0].fault) : 32'd0);

        if (r) begin
            mQ.delete();
            mHalted = 1'b0;
            mPc     = RESET_PC;
        end else begin
            if (rv) begin
                mQ.delete();
            end else if (mQ.size() > 0 && rdy) begin
                mQ.delete(0);
            end
            if ((!mHalted || rv) && mQ.size() < QDEPTH) begin
                flt     = (ea >= 32'(IMEM_DEPTH)) || (ea % 4 != 0);
                e.pc    = ea;
                e.instr = flt ? NOP_INSTR : memWord(ea);
                e.fault = flt;
                mQ.push_back(e);
                mHalted = flt;
                if (!flt) mPc = ea + 32'd4;
            end
        end
    endtask

    task automatic runCycles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'd0, rdy);
    endtask

    function automatic logic [31:0] randomTarget();
        logic [31:0] t;
        case ($urandom_range(0, 4))
            0, 1:    t = {17'd0, 13'($urandom_range(0, IMEM_DEPTH / 4 - 1)), 2'b00};
            2:       t = 32'(IMEM_DEPTH) - 32'(4 * $urandom_range(1, 3));
            3:       t = {17'd0, 13'($urandom_range(0, IMEM_DEPTH / 4 - 1)), 2'($urandom_range(1, 3))};
            default: t = $urandom() | 32'h0000_2000;
        endcase
        return t;
    endfunction

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.out_ready      = 1'b0;
        @(posedge clk);
        @(posedge clk);
        mQ.delete();
        mHalted = 1'b0;
        mPc     = RESET_PC;

        $display("[TB] reset and streaming");
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        runCycles(12, 1'b1);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        runCycles(10, 1'b0);
        runCycles(8, 1'b1);

        $display("[TB] redirect while full");
        runCycles(6, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b1);
        runCycles(4, 1'b1);

        $display("[TB] end of memory");
        applyStimulus(1'b0, 1'b1, 32'(IMEM_DEPTH - 4), 1'b1);
        runCycles(6, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'd0, 1'b1);
        runCycles(4, 1'b1);

        $display("[TB] misaligned redirect");
        applyStimulus(1'b0, 1'b1, 32'h102, 1'b1);
        runCycles(4, 1'b1);

        $display("[TB] reset during halt with full queue");
        applyStimulus(1'b0, 1'b1, 32'(IMEM_DEPTH - 12), 1'b0);
        runCycles(5, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h80, 1'b0);
        runCycles(4, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 11) == 0,
                          randomTarget(),
                          $urandom_range(0, 9) < 7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch sequencer for the RV32I core. Owns the fetch PC, drives the address of the combinational instruction memory, and buffers fetched words with their PCs in a small FIFO. Delivers them to decode over a valid/ready handshake. Handles branch/jump redirects with a single-cycle flush and flags out-of-range or misaligned fetches as faults.

## Interface

- IMEM_DEPTH, 8192, instruction memory size in bytes; power of two, ≥ 8.
- QDEPTH, 4, FIFO entries; power of two, ≥ 2.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset; word aligned.
- Derived: AW = $clog2(IMEM_DEPTH).

Ports:

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  AW  byte address to the instruction memory, which returns data combinationally in the same cycle.
- imem_instr  in  32  instruction word read at imem_addr.
- redirect_valid  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch target.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode accepts head entry.
- out_pc  out  32  PC of head entry.
- out_instr  out  32  instruction of head entry.
- out_fault  out  1  head entry is a fetch fault.
- q_count  out  $clog2(QDEPTH)+1  number of occupied entries.

## Operation

- **State machine**, two states: FETCH and HALT.
  - Reset state: FETCH with fetch_pc = RESET_PC.
- **Effective address**
  - ea = redirect_pc when redirect_valid is high; otherwise ea = fetch_pc.
  - imem_addr = ea[AW-1:0]. This path is combinational from redirect_pc.
- **Push**
  - Condition: state is FETCH (or redirect_valid is high), and the queue after this cycle's flush/pop has a free slot.
  - The entry written is {pc=ea, instr=imem_instr, fault=0}.
- **Fault**
  - Triggered when ea ≥ IMEM_DEPTH (32-bit unsigned compare) or ea[1:0] ≠ 0.
  - Pushed entry is {pc=ea, instr=32'h0000_0013 (NOP), fault=1}.
  - State goes to HALT. fetch_pc is unchanged.
- **Normal push**: fetch_pc ← ea + 4.
  - When the last word is fetched, ea + 4 = IMEM_DEPTH. The next fetch then faults; there is no wrap to 0.
- **HALT**
  - No pushes. The queue keeps draining.
  - Leaves HALT only on redirect_valid or rst.
- **Pop**: occurs when out_valid && out_ready. The head advances.
- **Redirect** (highest priority after rst)
  - All entries are discarded, including any entry being popped in the same cycle. Decode has already consumed a popped entry and must ignore it itself.
  - The redirect target is pushed in the same cycle, so the queue holds exactly 1 entry afterwards.
  - State returns to FETCH, or goes to HALT if the target faults.
- **Simultaneous push and pop when full**: allowed. The count is unchanged.
- **Outputs**: out_pc, out_instr and out_fault read from registered FIFO storage at the head pointer. They must stay stable while out_valid && !out_ready.
- **Pointers**: read and write pointers wrap modulo QDEPTH. q_count ranges from 0 to QDEPTH.

## Timing

- **Reset values**: out_valid = 0, q_count = 0, out_fault = 0, out_pc = 0, out_instr = 0. State = FETCH, fetch_pc = RESET_PC.
  - imem_addr = RESET_PC[AW-1:0] combinationally during reset.
- **Latency**: a word fetched in cycle N appears at the head in cycle N+1 if the queue was empty.
  - First out_valid comes 1 cycle after rst deasserts.
- **Steady-state throughput**: 1 instruction per cycle with out_ready held high. The queue holds at 1 entry.
- **Stalled decode**: the queue fills QDEPTH cycles after the stall starts, then pushes stop. fetch_pc holds at the next unfetched address.
- **Redirect in cycle N**: the cycle N+1 head is the redirect target, with q_count = 1.
- **Reset mid-operation**: the queue is emptied, HALT is cleared, and fetch_pc = RESET_PC on the next edge. redirect_valid is ignored that cycle.

## Test plan

- **Reset and stream**: with out_ready = 1 and memory words equal to their word index, the head sequence is pc 0,4,8,… with instr 0,1,2,…, and there are no gaps after the first valid.
- **Backpressure**
  - Hold out_ready = 0 for 10 cycles: q_count saturates at 4 and the head stays pc 0.
  - Release: pcs 0,4,8,12,16 arrive in order with no duplicates or drops.
- **Redirect while full**
  - With 4 entries queued, pulse redirect to 0x40 together with out_ready = 1.
  - Next cycle: q_count = 1, head pc 0x40. Then 0x44, 0x48 follow.
- **End of memory**
  - Redirect to IMEM_DEPTH−4. Entries are pc 0x1FFC (fault = 0), then pc 0x2000 (fault = 1, instr 0x13).
  - No further entries appear. Redirect to 0 resumes fetch.
- **Misaligned redirect**: redirect to 0x102 gives a single entry {pc 0x102, fault 1}, then HALT.
- **Reset during HALT with a full queue**: on the next cycle q_count = 0. One cycle later the head is RESET_PC.
